operand_fetch: RTL and testbench

- Sequencer directly downstream of the 64-entry x 1506-bit register-file read mux.
- Accepts one instruction word (opcode, src_a, src_b, dst) through a valid/ready handshake.
- Drives the mux's single read address over successive cycles and latches both operands.
- Presents the latched operand pair, opcode and dst to the modular-arithmetic datapath through a second valid/ready handshake.

---
 rtl/operand_fetch_if.sv | 53 +++++
 rtl/operand_fetch.sv | 112 +++++++++++
 tb/tb_operand_fetch.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_if.sv
// Instruction-in and operand-out valid/ready bundles for operand_fetch.
// slave is the sequencer side; master is the issuing/consuming side.
interface operand_fetch_if #(
  parameter int DW  = 1506,
  parameter int AW  = 7,
  parameter int OPW = 4
) ();

  logic           instr_valid;
  logic           instr_ready;
  logic [OPW-1:0] instr_op;
  logic [AW-1:0]  instr_src_a;
  logic [AW-1:0]  instr_src_b;
  logic [AW-1:0]  instr_dst;

  logic           op_valid;
  logic           op_ready;
  logic [OPW-1:0] op_code;
  logic [DW-1:0]  op_a;
  logic [DW-1:0]  op_b;
  logic [AW-1:0]  op_dst;

  modport slave (
    input  instr_valid,
    input  instr_op,
    input  instr_src_a,
    input  instr_src_b,
    input  instr_dst,
    output instr_ready,
    output op_valid,
    input  op_ready,
    output op_code,
    output op_a,
    output op_b,
    output op_dst
  );

  modport master (
    output instr_valid,
    output instr_op,
    output instr_src_a,
    output instr_src_b,
    output instr_dst,
    input  instr_ready,
    input  op_valid,
    output op_ready,
    input  op_code,
    input  op_a,
    input  op_b,
    input  op_dst
  );

endinterface

// File: rtl/operand_fetch.sv
// Operand fetch sequencer: reads two register-file operands through a
// single combinational read port and hands them to the datapath.
module operand_fetch #(
  parameter int DW   = 1506,
  parameter int AW   = 7,
  parameter int OPW  = 4,
  parameter int NREG = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  operand_fetch_if.slave bus,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] mem_rd,
  output logic          addr_err,
  output logic          busy
);

  // RD_B reads operand A of a distinct pair; RD_A is always the last read.
  typedef enum logic [1:0] {
    IDLE,
    RD_B,
    RD_A,
    OUT
  } state_t;

  state_t state;
  state_t state_nx;

  logic [AW-1:0] src_b_q;
  logic          same_q;
  logic          accept;
  logic          same_src;
  logic          oor;

  assign accept   = bus.instr_valid && (state == IDLE);
  assign same_src = (bus.instr_src_a == bus.instr_src_b);
  assign oor      = (rd_addr >= AW'(NREG));

  assign bus.instr_ready = (state == IDLE);
  assign bus.op_valid    = (state == OUT);
  assign busy            = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = same_src ? RD_A : RD_B;
        end
      end
      RD_B: state_nx = RD_A;
      RD_A: state_nx = OUT;
      OUT: begin
        if (bus.op_ready) begin
          state_nx = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_addr     <= '0;
      src_b_q     <= '0;
      same_q      <= 1'b0;
      addr_err    <= 1'b0;
      bus.op_code <= '0;
      bus.op_dst  <= '0;
      bus.op_a    <= '0;
      bus.op_b    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            bus.op_code <= bus.instr_op;
            bus.op_dst  <= bus.instr_dst;
            src_b_q     <= bus.instr_src_b;
            same_q      <= same_src;
            rd_addr     <= bus.instr_src_a;
          end
        end
        RD_B: begin
          bus.op_a <= mem_rd;
          rd_addr  <= src_b_q;
          if (oor) begin
            addr_err <= 1'b1;
          end
        end
        RD_A: begin
          bus.op_b <= mem_rd;
          if (same_q) begin
            bus.op_a <= mem_rd;
          end
          if (oor) begin
            addr_err <= 1'b1;
          end
        end
        OUT: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a transaction-level reference
// model compared every cycle plus literal expectations.
module tb_operand_fetch;

  localparam int DW   = 1506;
  localparam int AW   = 7;
  localparam int OPW  = 4;
  localparam int NREG = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] mem_rd;
  logic          addr_err;
  logic          busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  operand_fetch_if #(.DW(DW), .AW(AW), .OPW(OPW)) bus ();

  operand_fetch #(.DW(DW), .AW(AW), .OPW(OPW), .NREG(NREG)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .rd_addr  (rd_addr),
    .mem_rd   (mem_rd),
    .addr_err (addr_err),
    .busy     (busy)
  );

  logic [DW-1:0] regs [NREG];
  logic [DW-1:0] exp5;

  function automatic logic [DW-1:0] rdv(input logic [AW-1:0] a);
    if (a < AW'(NREG)) return regs[a[5:0]];
    return '0;
  endfunction

  assign mem_rd = rdv(rd_addr);

  task automatic chk(input string name,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Reference model: counts remaining read edges per transaction.
  logic          m_live = 1'b0;
  logic          m_busy = 1'b0;
  logic          m_valid = 1'b0;
  logic          m_err = 1'b0;
  int            m_left = 0;
  logic [AW-1:0] m_rd = '0;
  logic [AW-1:0] m_srcb = '0;
  logic [DW-1:0] m_a = '0;
  logic [DW-1:0] m_b = '0;
  logic [OPW-1:0] m_op = '0;
  logic [AW-1:0] m_dst = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_live  = 1'b1;
      m_busy  = 1'b0;
      m_valid = 1'b0;
      m_err   = 1'b0;
      m_left  = 0;
      m_rd    = '0;
    end else if (m_valid) begin
      if (bus.op_ready) begin
        m_valid = 1'b0;
        m_busy  = 1'b0;
      end
    end else if (m_busy) begin
      if (m_rd >= AW'(NREG)) m_err = 1'b1;
      if (m_left == 2) m_rd = m_srcb;
      m_left--;
      if (m_left == 0) m_valid = 1'b1;
    end else if (bus.instr_valid) begin
      m_busy = 1'b1;
      m_rd   = bus.instr_src_a;
      m_srcb = bus.instr_src_b;
      m_left = (bus.instr_src_a == bus.instr_src_b) ? 1 : 2;
      m_a    = rdv(bus.instr_src_a);
      m_b    = rdv(bus.instr_src_b);
      m_op   = bus.instr_op;
      m_dst  = bus.instr_dst;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("m_op_valid", DW'(bus.op_valid), DW'(m_valid));
      chk("m_instr_ready", DW'(bus.instr_ready), DW'(!m_busy));
      chk("m_busy", DW'(busy), DW'(m_busy));
      chk("m_rd_addr", DW'(rd_addr), DW'(m_rd));
      chk("m_addr_err", DW'(addr_err), DW'(m_err));
      if (m_valid) begin
        chk("m_op_a", bus.op_a, m_a);
        chk("m_op_b", bus.op_b, m_b);
        chk("m_op_code", DW'(bus.op_code), DW'(m_op));
        chk("m_op_dst", DW'(bus.op_dst), DW'(m_dst));
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send(input logic [OPW-1:0] op, input logic [AW-1:0] a,
                      input logic [AW-1:0] b, input logic [AW-1:0] d);
    bus.instr_op    = op;
    bus.instr_src_a = a;
    bus.instr_src_b = b;
    bus.instr_dst   = d;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) begin
      regs[i] = {2'b11, {47{32'h9E3779B9 ^ i}}};
    end
    exp5     = {753{2'b10}};
    regs[5]  = exp5;
    regs[9]  = DW'(12'h123);
    bus.instr_valid = 1'b0;
    bus.instr_op    = '0;
    bus.instr_src_a = '0;
    bus.instr_src_b = '0;
    bus.instr_dst   = '0;
    bus.op_ready    = 1'b1;
    rst_n = 1'b0;
    step();
    step();
    chk("rst_op_valid", DW'(bus.op_valid), '0);
    chk("rst_instr_ready", DW'(bus.instr_ready), DW'(1));
    chk("rst_busy", DW'(busy), '0);
    chk("rst_op_a", bus.op_a, '0);
    chk("rst_addr_err", DW'(addr_err), '0);
    rst_n = 1'b1;
    step();
    step();
    chk("idle_busy", DW'(busy), '0);
    chk("idle_rd_addr", DW'(rd_addr), '0);

    send(4'd3, 7'd5, 7'd9, 7'd12);
    chk("dist_rd_a", DW'(rd_addr), DW'(5));
    chk("dist_nv1", DW'(bus.op_valid), '0);
    step();
    chk("dist_rd_b", DW'(rd_addr), DW'(9));
    chk("dist_nv2", DW'(bus.op_valid), '0);
    step();
    chk("dist_valid", DW'(bus.op_valid), DW'(1));
    chk("dist_op_a", bus.op_a, exp5);
    chk("dist_op_b", bus.op_b, DW'(12'h123));
    chk("dist_dst", DW'(bus.op_dst), DW'(12));
    chk("dist_code", DW'(bus.op_code), DW'(3));
    step();
    chk("dist_drop", DW'(bus.op_valid), '0);
    chk("dist_ready", DW'(bus.instr_ready), DW'(1));

    send(4'd6, 7'd20, 7'd20, 7'd21);
    chk("eq_nv", DW'(bus.op_valid), '0);
    step();
    chk("eq_valid", DW'(bus.op_valid), DW'(1));
    chk("eq_op_a", bus.op_a, regs[20]);
    chk("eq_op_b", bus.op_b, regs[20]);
    step();

    bus.op_ready = 1'b0;
    send(4'd7, 7'd1, 7'd2, 7'd33);
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      bus.instr_valid = 1'b1;
      bus.instr_src_a = 7'd40;
      bus.instr_src_b = 7'd41;
      step();
      chk("bp_valid", DW'(bus.op_valid), DW'(1));
      chk("bp_op_a", bus.op_a, regs[1]);
      chk("bp_op_b", bus.op_b, regs[2]);
      chk("bp_ready", DW'(bus.instr_ready), '0);
    end
    bus.instr_valid = 1'b0;
    bus.op_ready    = 1'b1;
    step();
    chk("bp_xfer", DW'(bus.op_valid), '0);
    step();
    chk("bp_idle", DW'(busy), '0);

    send(4'd1, 7'd64, 7'd2, 7'd5);
    step();
    step();
    chk("oor_op_a", bus.op_a, '0);
    chk("oor_op_b", bus.op_b, regs[2]);
    chk("oor_err", DW'(addr_err), DW'(1));
    step();
    send(4'd2, 7'd3, 7'd4, 7'd6);
    step();
    step();
    chk("oor_sticky", DW'(addr_err), DW'(1));
    chk("oor_next_b", bus.op_b, regs[4]);
    step();

    send(4'd4, 7'd10, 7'd11, 7'd7);
    step();
    rst_n = 1'b0;
    step();
    chk("mid_valid", DW'(bus.op_valid), '0);
    chk("mid_busy", DW'(busy), '0);
    chk("mid_op_a", bus.op_a, '0);
    chk("mid_op_b", bus.op_b, '0);
    chk("mid_err", DW'(addr_err), '0);
    rst_n = 1'b1;
    step();
    send(4'd5, 7'd30, 7'd31, 7'd8);
    step();
    step();
    chk("post_valid", DW'(bus.op_valid), DW'(1));
    chk("post_op_a", bus.op_a, regs[30]);
    chk("post_op_b", bus.op_b, regs[31]);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
